// File: rtl/csr_file_pkg.sv
// ---------------------------------------------------------------------------
// csr_file_pkg
//   Shared definitions for the CSR file: the CSR opcodes seen from the ID-stage
//   decoder (values mirror defs.v), CSR addresses, field bit positions,
//   writable-bit masks, exception codes and the masked-write merge helper.
// ---------------------------------------------------------------------------
package csr_file_pkg;

  // CSR instruction opcodes (must match the decoder's defs.v encoding)
  localparam logic [7:0] OP_CSRRD   = 8'h30;
  localparam logic [7:0] OP_CSRWR   = 8'h31;
  localparam logic [7:0] OP_CSRXCHG = 8'h32;

  // CSR addresses
  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  // Field positions
  localparam int CRMD_IE       = 2;   // CRMD[1:0]=PLV, [2]=IE, [3]=DA
  localparam int PRMD_PIE      = 2;   // PRMD[1:0]=PPLV, [2]=PIE
  localparam int ESTAT_IS_TI   = 11;  // timer interrupt status
  localparam int ESTAT_IS_IPI  = 12;  // inter-processor interrupt status
  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;

  // Reset value and writable bits
  localparam logic [8:0]  CRMD_RESET    = 9'h008;   // DA=1, PLV=0, IE=0
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1BFF; // bit 10 is reserved

  // Exception codes
  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  // Masked write: bits set in mask take the new data, the rest keep old.
  function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// ---------------------------------------------------------------------------
// csr_file_if
//   Bundle between the WB stage (master) and the CSR file (slave).
//   Handshake: csr_valid, wb_ex and ertn_flush are single-cycle commit
//   strobes qualified by the rising clock edge; there is no ready, the CSR
//   file accepts every commit in the cycle it is presented.
//   master drives: csr_valid, csr_op, csr_num, csr_rj, csr_rd, wb_ex,
//                  wb_ecode, wb_esubcode, wb_pc, ertn_flush, hw_int_in,
//                  ipi_int_in
//   slave drives:  csr_rvalue, has_int, ex_entry, era_out
// ---------------------------------------------------------------------------
interface csr_file_if;
  logic        csr_valid;
  logic [7:0]  csr_op;
  logic [13:0] csr_num;
  logic [31:0] csr_rj;
  logic [31:0] csr_rd;
  logic [31:0] csr_rvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] era_out;

  modport master (
    output csr_valid, csr_op, csr_num, csr_rj, csr_rd,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
    output hw_int_in, ipi_int_in,
    input  csr_rvalue, has_int, ex_entry, era_out
  );

  modport slave (
    input  csr_valid, csr_op, csr_num, csr_rj, csr_rd,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, ertn_flush,
    input  hw_int_in, ipi_int_in,
    output csr_rvalue, has_int, ex_entry, era_out
  );
endinterface

// File: rtl/csr_timer.sv
// ---------------------------------------------------------------------------
// csr_timer
//   Constant-frequency timer behind TCFG/TVAL. Only present when the
//   CSR_TIMER_EN macro is defined.
//   Ports:
//     clk, reset     core clock, asynchronous active-high reset
//     i_load         TCFG is written this cycle
//     i_load_val     value being written to TCFG (InitVal in [31:2])
//     i_tcfg         current TCFG (En bit0, Periodic bit1, InitVal [31:2])
//     o_tval         TVAL
//     o_timer_int    one-cycle pulse when the count reaches zero while enabled
// ---------------------------------------------------------------------------
`ifdef CSR_TIMER_EN
module csr_timer
  import csr_file_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic [31:0] i_tcfg,
  output logic [31:0] o_tval,
  output logic        o_timer_int
);

  logic [31:0] r_tval;
  logic [31:0] w_reload;
  logic        w_en;

  assign w_en     = i_tcfg[TCFG_EN];
  assign w_reload = {i_tcfg[31:2], 2'b00};

  // A TCFG write restarts the count, so it also masks the expiry pulse.
  assign o_timer_int = w_en && (r_tval == 32'h0) && !i_load;
  assign o_tval      = r_tval;

  // All-ones marks an expired one-shot timer: a load can never produce it
  // (InitVal is shifted left by two), so it doubles as the "hold" state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tval <= 32'h0;
    end else if (i_load) begin
      r_tval <= {i_load_val[31:2], 2'b00};
    end else if (o_timer_int) begin
      r_tval <= i_tcfg[TCFG_PERIODIC] ? w_reload : 32'hFFFF_FFFF;
    end else if (w_en && (r_tval != 32'h0) && (r_tval != 32'hFFFF_FFFF)) begin
      r_tval <= r_tval - 32'h1;
    end
  end

endmodule
`endif

// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
//   CSR register file with exception entry / ERTN side effects and
//   interrupt pending logic.
//   Ports:
//     clk, reset   core clock, asynchronous active-high reset
//     bus          csr_file_if.slave: CSR read/write commit, exception and
//                  ERTN commit, interrupt levels; returns csr_rvalue
//                  (combinational pre-write read), has_int, ex_entry, era_out
//   Parameter:
//     TID_INIT     reset value of TID
//   Build option:
//     CSR_TIMER_EN defined   -> TCFG/TVAL/TICLR and the timer interrupt exist
//     CSR_TIMER_EN undefined -> those CSRs read 0, writes ignored, IS[11]=0
// ---------------------------------------------------------------------------
module csr_file
  import csr_file_pkg::*;
#(
  parameter logic [31:0] TID_INIT = 32'h0
) (
  input  logic   clk,
  input  logic   reset,
  csr_file_if.slave bus
);

  logic [8:0]  r_crmd;
  logic [2:0]  r_prmd;
  logic [12:0] r_ecfg_lie;
  logic [12:0] r_estat_is;
  logic [5:0]  r_estat_ecode;
  logic [8:0]  r_estat_esub;
  logic [31:0] r_era;
  logic [25:0] r_eentry_va;
  logic [31:0] r_save [0:3];
  logic [31:0] r_tid;

  logic        w_we;
  logic [31:0] w_mask;
  logic [31:0] w_wdata;
  logic [31:0] w_rvalue;
  logic        w_ticlr_clr;
  logic [31:0] w_tcfg_q;
  logic [31:0] w_tval;
  logic        w_timer_int;

  // A committing exception squashes the CSR write of the same instruction.
  assign w_we = bus.csr_valid && !bus.wb_ex &&
                ((bus.csr_op == OP_CSRWR) || (bus.csr_op == OP_CSRXCHG));
  assign w_mask  = (bus.csr_op == OP_CSRXCHG) ? bus.csr_rj : 32'hFFFF_FFFF;
  // Merging against the read value is safe: reserved bits read 0 and are
  // dropped again when the per-register field slice is stored.
  assign w_wdata = csr_merge(w_rvalue, bus.csr_rd, w_mask);
  assign w_ticlr_clr = w_we && (bus.csr_num == CSR_TICLR) && w_wdata[0];

`ifdef CSR_TIMER_EN
  logic [31:0] r_tcfg;
  logic        w_tcfg_we;

  assign w_tcfg_we = w_we && (bus.csr_num == CSR_TCFG);
  assign w_tcfg_q  = r_tcfg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tcfg <= 32'h0;
    end else if (w_tcfg_we) begin
      r_tcfg <= w_wdata;
    end
  end

  csr_timer u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_tcfg_we),
    .i_load_val  (w_wdata),
    .i_tcfg      (r_tcfg),
    .o_tval      (w_tval),
    .o_timer_int (w_timer_int)
  );
`else
  assign w_tcfg_q    = 32'h0;
  assign w_tval      = 32'h0;
  assign w_timer_int = 1'b0;
`endif

  // Read mux: pure function of registered state, no write bypass.
  always_comb begin
    w_rvalue = 32'h0;
    case (bus.csr_num)
      CSR_CRMD:   w_rvalue = {23'h0, r_crmd};
      CSR_PRMD:   w_rvalue = {29'h0, r_prmd};
      CSR_ECFG:   w_rvalue = {19'h0, r_ecfg_lie};
      CSR_ESTAT:  w_rvalue = {1'b0, r_estat_esub, r_estat_ecode, 3'b000, r_estat_is};
      CSR_ERA:    w_rvalue = r_era;
      CSR_EENTRY: w_rvalue = {r_eentry_va, 6'h00};
      CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                  w_rvalue = r_save[bus.csr_num[1:0]];
      CSR_TID:    w_rvalue = r_tid;
      CSR_TCFG:   w_rvalue = w_tcfg_q;
      CSR_TVAL:   w_rvalue = w_tval;
      default:    w_rvalue = 32'h0;   // TICLR and unknown addresses
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_crmd        <= CRMD_RESET;
      r_prmd        <= 3'h0;
      r_ecfg_lie    <= 13'h0;
      r_estat_is    <= 13'h0;
      r_estat_ecode <= 6'h0;
      r_estat_esub  <= 9'h0;
      r_era         <= 32'h0;
      r_eentry_va   <= 26'h0;
      for (int i = 0; i < 4; i++) r_save[i] <= 32'h0;
      r_tid         <= TID_INIT;
    end else begin
      // Interrupt levels are sampled every cycle.
      r_estat_is[9:2]          <= bus.hw_int_in;
      r_estat_is[10]           <= 1'b0;
      r_estat_is[ESTAT_IS_IPI] <= bus.ipi_int_in;
      // A timer expiry in the same cycle wins over a TICLR clear.
      r_estat_is[ESTAT_IS_TI]  <= w_timer_int | (r_estat_is[ESTAT_IS_TI] & ~w_ticlr_clr);

      if (w_we) begin
        case (bus.csr_num)
          CSR_CRMD:   r_crmd            <= w_wdata[8:0];
          CSR_PRMD:   r_prmd            <= w_wdata[2:0];
          CSR_ECFG:   r_ecfg_lie        <= w_wdata[12:0] & ECFG_LIE_MASK;
          CSR_ESTAT:  r_estat_is[1:0]   <= w_wdata[1:0];
          CSR_ERA:    r_era             <= w_wdata;
          CSR_EENTRY: r_eentry_va       <= w_wdata[31:6];
          CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                      r_save[bus.csr_num[1:0]] <= w_wdata;
          CSR_TID:    r_tid             <= w_wdata;
          default: ;
        endcase
      end

      // Exception / ERTN updates come last so they override the write on
      // the PLV/IE fields they own.
      if (bus.wb_ex) begin
        r_prmd        <= r_crmd[PRMD_PIE:0];
        r_crmd[2:0]   <= 3'b000;
        r_era         <= bus.wb_pc;
        r_estat_ecode <= bus.wb_ecode;
        r_estat_esub  <= bus.wb_esubcode;
      end else if (bus.ertn_flush) begin
        r_crmd[CRMD_IE:0] <= r_prmd;
      end
    end
  end

  assign bus.csr_rvalue = w_rvalue;
  assign bus.has_int    = r_crmd[CRMD_IE] && |(r_estat_is & r_ecfg_lie);
  assign bus.ex_entry   = {r_eentry_va, 6'h00};
  assign bus.era_out    = r_era;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;
  import csr_file_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csr_file_if bus ();

  csr_file #(.TID_INIT(32'h0000_00A5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.csr_valid   = 1'b0;
    bus.csr_op      = 8'h0;
    bus.csr_num     = 14'h0;
    bus.csr_rj      = 32'h0;
    bus.csr_rd      = 32'h0;
    bus.wb_ex       = 1'b0;
    bus.wb_ecode    = 6'h0;
    bus.wb_esubcode = 9'h0;
    bus.wb_pc       = 32'h0;
    bus.ertn_flush  = 1'b0;
  endtask

  // One WB commit cycle; old = csr_rvalue seen during that cycle.
  task automatic commit(input logic v, input logic [7:0] op, input logic [13:0] num,
                        input logic [31:0] rj, input logic [31:0] rd,
                        input logic ex, input logic [5:0] ec, input logic [8:0] es,
                        input logic [31:0] pc, input logic ertn,
                        output logic [31:0] old);
    @(negedge clk);
    bus.csr_valid   = v;
    bus.csr_op      = op;
    bus.csr_num     = num;
    bus.csr_rj      = rj;
    bus.csr_rd      = rd;
    bus.wb_ex       = ex;
    bus.wb_ecode    = ec;
    bus.wb_esubcode = es;
    bus.wb_pc       = pc;
    bus.ertn_flush  = ertn;
    #1 old = bus.csr_rvalue;
    @(posedge clk);
    #1 bus_idle();
  endtask

  task automatic csr_wr(input logic [13:0] num, input logic [31:0] rd);
    logic [31:0] unused_old;
    commit(1'b1, OP_CSRWR, num, 32'h0, rd, 1'b0, 6'h0, 9'h0, 32'h0, 1'b0, unused_old);
  endtask

  task automatic csr_rd(input logic [13:0] num, output logic [31:0] val);
    @(negedge clk);
    bus.csr_num = num;
    #1 val = bus.csr_rvalue;
  endtask

  task automatic check_csr(input string tag, input logic [13:0] num, input logic [31:0] exp);
    logic [31:0] got;
    csr_rd(num, got);
    check(tag, got, exp);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] old;
  logic [31:0] got;
  logic [31:0] save_vals [0:2];
  int          k;

  initial begin
    bus_idle();
    bus.hw_int_in  = 8'h0;
    bus.ipi_int_in = 1'b0;
    save_vals[0] = 32'h0000_0000;
    save_vals[1] = 32'hFFFF_FFFF;
    save_vals[2] = 32'h5A5A_A5A5;

    repeat (3) @(posedge clk);
    #1 check("crmd_in_reset", bus.csr_rvalue, 32'h8);  // csr_num = 0
    @(negedge clk) reset = 1'b0;

    // reset state
    check_csr("rst_crmd", CSR_CRMD, 32'h8);
    check_csr("rst_tval", CSR_TVAL, 32'h0);
    check_csr("rst_prmd", CSR_PRMD, 32'h0);
    check_csr("rst_tid", CSR_TID, 32'h0000_00A5);
    check("rst_has_int", {31'h0, bus.has_int}, 32'h0);

    // CSRWR then CSRXCHG on SAVE0
    csr_wr(CSR_SAVE0, 32'hDEAD_BEEF);
    commit(1'b1, OP_CSRXCHG, CSR_SAVE0, 32'h0000_FFFF, 32'h1234_5678,
           1'b0, 6'h0, 9'h0, 32'h0, 1'b0, old);
    check("xchg_old", old, 32'hDEAD_BEEF);
    check_csr("xchg_new", CSR_SAVE0, 32'hDEAD_5678);

    // reserved bits and unknown addresses
    csr_wr(CSR_ECFG, 32'hFFFF_FFFF);
    check_csr("ecfg_rsvd", CSR_ECFG, 32'h0000_1BFF);
    csr_wr(CSR_ESTAT, 32'hFFFF_FFFF);
    check_csr("estat_sw_only", CSR_ESTAT, 32'h0000_0003);
    check("ie0_no_int", {31'h0, bus.has_int}, 32'h0);
    csr_wr(CSR_ESTAT, 32'h0);
    csr_wr(CSR_ECFG, 32'h0);
    csr_wr(CSR_EENTRY, 32'hFFFF_FFFF);
    check_csr("eentry_rsvd", CSR_EENTRY, 32'hFFFF_FFC0);
    check("ex_entry", bus.ex_entry, 32'hFFFF_FFC0);
    csr_wr(14'h007, 32'h1234);
    check_csr("unknown_007", 14'h007, 32'h0);
    check_csr("unknown_043", 14'h043, 32'h0);
    check_csr("ticlr_reads0", CSR_TICLR, 32'h0);

    // exception entry, with a suppressed CSRWR SAVE0=1 in the same cycle
    csr_wr(CSR_CRMD, 32'h7);
    check_csr("crmd_7", CSR_CRMD, 32'h7);
    commit(1'b1, OP_CSRWR, CSR_SAVE0, 32'h0, 32'h1, 1'b1, ECODE_SYS, 9'h0,
           32'h1C00_0100, 1'b0, old);
    check_csr("ex_crmd", CSR_CRMD, 32'h0);
    check_csr("ex_prmd", CSR_PRMD, 32'h7);
    check_csr("ex_era", CSR_ERA, 32'h1C00_0100);
    check("era_out", bus.era_out, 32'h1C00_0100);
    check_csr("ex_estat", CSR_ESTAT, 32'h000B_0000);
    check_csr("ex_save0_kept", CSR_SAVE0, 32'hDEAD_5678);

    // ERTN restores PLV/IE; coincident CSRWR CRMD keeps its other fields
    commit(1'b0, 8'h0, 14'h0, 32'h0, 32'h0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b1, old);
    check_csr("ertn_crmd", CSR_CRMD, 32'h7);
    commit(1'b1, OP_CSRWR, CSR_CRMD, 32'h0, 32'h1F0, 1'b0, 6'h0, 9'h0, 32'h0, 1'b1, old);
    check_csr("ertn_wr_crmd", CSR_CRMD, 32'h1F7);
    csr_wr(CSR_CRMD, 32'h0);

    // hardware interrupt gated by IE
    csr_wr(CSR_ECFG, 32'h4);
    bus.hw_int_in = 8'h01;
    tick();
    check_csr("hw_is2", CSR_ESTAT, 32'h000B_0004);
    check("hw_ie0", {31'h0, bus.has_int}, 32'h0);
    csr_wr(CSR_CRMD, 32'h4);
    check("hw_ie1", {31'h0, bus.has_int}, 32'h1);
    bus.hw_int_in = 8'h00;
    tick();
    check("hw_drop", {31'h0, bus.has_int}, 32'h0);

    // IPI
    csr_wr(CSR_ECFG, 32'h1000);
    bus.ipi_int_in = 1'b1;
    tick();
    check("ipi_int", {31'h0, bus.has_int}, 32'h1);
    check_csr("ipi_is12", CSR_ESTAT, 32'h000B_1000);
    bus.ipi_int_in = 1'b0;
    tick();
    check("ipi_drop", {31'h0, bus.has_int}, 32'h0);

    // timer (CRMD.IE is still 1)
    csr_wr(CSR_ECFG, 32'h800);
`ifdef CSR_TIMER_EN
    csr_wr(CSR_TCFG, 32'h0000_0013);
    k = 41;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (bus.has_int) begin
        k = c;
        break;
      end
    end
    check("timer_rise_cycles", k, 17);
    check_csr("timer_reload", CSR_TVAL, 32'h10);
    check_csr("tcfg_rd", CSR_TCFG, 32'h13);
    csr_wr(CSR_TICLR, 32'h1);
    check("ticlr_clear", {31'h0, bus.has_int}, 32'h0);
    csr_wr(CSR_TCFG, 32'h0);
`else
    csr_wr(CSR_TCFG, 32'h0000_0013);
    check_csr("tcfg_absent", CSR_TCFG, 32'h0);
    check_csr("tval_absent", CSR_TVAL, 32'h0);
    repeat (20) tick();
    check("no_timer_int", {31'h0, bus.has_int}, 32'h0);
`endif

    // exception with extreme ecode/esubcode
    commit(1'b0, 8'h0, 14'h0, 32'h0, 32'h0, 1'b1, 6'h3F, 9'h1FF,
           32'h1C00_0200, 1'b0, old);
    check_csr("ex2_estat", CSR_ESTAT, 32'h7FFF_0000);
    check_csr("ex2_prmd", CSR_PRMD, 32'h4);
    check_csr("ex2_crmd", CSR_CRMD, 32'h0);

    // CSRRD never writes
    commit(1'b1, OP_CSRRD, CSR_SAVE1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           1'b0, 6'h0, 9'h0, 32'h0, 1'b0, old);
    check_csr("csrrd_nowrite", CSR_SAVE1, 32'h0);

    // SAVE1..3 through the expected queue, plus an all-zero XCHG mask
    for (int i = 0; i < 3; i++) begin
      csr_wr(CSR_SAVE1 + 14'(i), save_vals[i]);
      exp_q.push_back(save_vals[i]);
    end
    commit(1'b1, OP_CSRXCHG, CSR_SAVE3, 32'h0, 32'hFFFF_FFFF,
           1'b0, 6'h0, 9'h0, 32'h0, 1'b0, old);
    for (int i = 0; i < 3; i++) begin
      csr_rd(CSR_SAVE1 + 14'(i), got);
      check($sformatf("save%0d", i + 1), got, exp_q.pop_front());
    end
    csr_wr(CSR_TID, 32'hCAFE_F00D);
    check_csr("tid_wr", CSR_TID, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
